mem_port_arbiter: RTL and testbench

Shares one single-port, variable-latency memory between the CPU's instruction-fetch port and its load/store port. Both requesters use a req/gnt handshake. The arbiter serialises their accesses and generates word-aligned addresses, byte enables and lane-replicated store data. Load data comes back right-aligned so the CPU's existing size/sign-extension logic can consume it. It sits between the CPU core and the memory model/BRAM wrapper.

---
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: CPU fetch/data request ports and the shared memory port.
// Rev 1.0
`default_nettype none

interface mem_port_arbiter_if;
   logic        i_if_req;
   logic [31:0] i_if_addr;
   logic        o_if_gnt;
   logic        o_if_rvalid;
   logic [31:0] o_if_rdata;
   logic        i_d_req;
   logic        i_d_we;
   logic [1:0]  i_d_size;
   logic [31:0] i_d_addr;
   logic [31:0] i_d_wdata;
   logic        o_d_gnt;
   logic        o_d_rvalid;
   logic [31:0] o_d_rdata;
   logic        o_d_err;
   logic        o_m_req;
   logic        o_m_we;
   logic [31:0] o_m_addr;
   logic [3:0]  o_m_be;
   logic [31:0] o_m_wdata;
   logic        i_m_ack;
   logic [31:0] i_m_rdata;

   // Arbiter side
   modport slave (
      input  i_if_req, i_if_addr,
      output o_if_gnt, o_if_rvalid, o_if_rdata,
      input  i_d_req, i_d_we, i_d_size, i_d_addr, i_d_wdata,
      output o_d_gnt, o_d_rvalid, o_d_rdata, o_d_err,
      output o_m_req, o_m_we, o_m_addr, o_m_be, o_m_wdata,
      input  i_m_ack, i_m_rdata
   );

   // CPU and memory side
   modport master (
      output i_if_req, i_if_addr,
      input  o_if_gnt, o_if_rvalid, o_if_rdata,
      output i_d_req, i_d_we, i_d_size, i_d_addr, i_d_wdata,
      input  o_d_gnt, o_d_rvalid, o_d_rdata, o_d_err,
      input  o_m_req, o_m_we, o_m_addr, o_m_be, o_m_wdata,
      output i_m_ack, i_m_rdata
   );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and load/store onto one variable-latency memory port.
// Build option MEM_ARB_MISALIGN_CHECK_EN rejects misaligned half/word accesses. Rev 1.0
`default_nettype none

module mem_port_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   mem_port_arbiter_if.slave   bus
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_D  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] starve_cnt;
   logic             if_gnt, d_gnt;

   logic [31:0] d_addr_al;
   logic [3:0]  d_lanes;
   logic [31:0] d_wrep;
   logic        d_bad;

   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        d_we;
   logic [1:0]  d_off;
   logic        if_rvalid, d_rvalid, d_err;
   logic [31:0] if_rdata, d_rdata;

   logic unused_bits;
   assign unused_bits = &{1'b0, bus.i_if_addr[1:0]};

   always_comb begin
      d_addr_al = bus.i_d_addr;
      d_lanes   = 4'b0000;
      d_wrep    = '0;
      d_bad     = 1'b0;
      case (bus.i_d_size)
         2'b01: begin
            d_lanes = 4'b0001 << bus.i_d_addr[1:0];
            d_wrep  = {4{bus.i_d_wdata[7:0]}};
         end
         2'b10: begin
`ifdef MEM_ARB_MISALIGN_CHECK_EN
            d_bad = bus.i_d_addr[0];
`else
            d_addr_al[0] = 1'b0;
`endif
            d_lanes = 4'b0011 << {bus.i_d_addr[1], 1'b0};
            d_wrep  = {2{bus.i_d_wdata[15:0]}};
         end
         2'b11: begin
`ifdef MEM_ARB_MISALIGN_CHECK_EN
            d_bad = |bus.i_d_addr[1:0];
`else
            d_addr_al[1:0] = 2'b00;
`endif
            d_lanes = 4'b1111;
            d_wrep  = bus.i_d_wdata;
         end
         default: d_bad = 1'b1;
      endcase
   end

   // Data has priority unless fetch has been passed over STARVE_MAX times in a row.
   always_comb begin
      state_nxt = state;
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      case (state)
         IDLE: begin
            if (i_rst_n) begin
               if (bus.i_d_req && (!bus.i_if_req || starve_cnt != STARVE_LIM)) begin
                  d_gnt = 1'b1;
                  if (!d_bad) state_nxt = BUSY_D;
               end else if (bus.i_if_req) begin
                  if_gnt    = 1'b1;
                  state_nxt = BUSY_IF;
               end
            end
         end
         BUSY_IF, BUSY_D: begin
            if (bus.i_m_ack) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         starve_cnt <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_be     <= '0;
         mem_wdata  <= '0;
         d_we       <= 1'b0;
         d_off      <= '0;
         if_rvalid  <= 1'b0;
         if_rdata   <= '0;
         d_rvalid   <= 1'b0;
         d_rdata    <= '0;
         d_err      <= 1'b0;
      end else begin
         state     <= state_nxt;
         if_rvalid <= 1'b0;
         if_rdata  <= '0;
         d_rvalid  <= 1'b0;
         d_rdata   <= '0;
         d_err     <= 1'b0;

         if (if_gnt) begin
            starve_cnt <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= {bus.i_if_addr[31:2], 2'b00};
            mem_be     <= 4'b1111;
            mem_wdata  <= '0;
         end

         if (d_gnt) begin
            if (bus.i_if_req && starve_cnt != STARVE_LIM)
               starve_cnt <= starve_cnt + 1'b1;
            if (d_bad) begin
               d_rvalid <= 1'b1;
               d_err    <= 1'b1;
            end else begin
               mem_we    <= bus.i_d_we;
               mem_addr  <= {d_addr_al[31:2], 2'b00};
               mem_be    <= bus.i_d_we ? d_lanes : 4'b1111;
               mem_wdata <= bus.i_d_we ? d_wrep : 32'd0;
               d_we      <= bus.i_d_we;
               d_off     <= d_addr_al[1:0];
            end
         end

         if (state == BUSY_IF && bus.i_m_ack) begin
            if_rvalid <= 1'b1;
            if_rdata  <= bus.i_m_rdata;
         end

         if (state == BUSY_D && bus.i_m_ack) begin
            d_rvalid <= 1'b1;
            d_rdata  <= d_we ? 32'd0 : (bus.i_m_rdata >> {d_off, 3'b000});
         end
      end
   end

   assign bus.o_if_gnt    = if_gnt;
   assign bus.o_if_rvalid = if_rvalid;
   assign bus.o_if_rdata  = if_rdata;
   assign bus.o_d_gnt     = d_gnt;
   assign bus.o_d_rvalid  = d_rvalid;
   assign bus.o_d_rdata   = d_rdata;
   assign bus.o_d_err     = d_err;
   assign bus.o_m_req     = (state != IDLE);
   assign bus.o_m_we      = mem_we;
   assign bus.o_m_addr    = mem_addr;
   assign bus.o_m_be      = mem_be;
   assign bus.o_m_wdata   = mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, lane steering, latency and reset.
// Rev 1.0
`default_nettype none

module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(.STARVE_MAX(4)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.i_if_req  = 1'b0;
      bus.i_if_addr = '0;
      bus.i_d_req   = 1'b0;
      bus.i_d_we    = 1'b0;
      bus.i_d_size  = 2'b00;
      bus.i_d_addr  = '0;
      bus.i_d_wdata = '0;
      bus.i_m_ack   = 1'b0;
      bus.i_m_rdata = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      step();
      step();
      #1;
      tests++;
      if ({bus.o_m_req, bus.o_m_we, bus.o_m_be, bus.o_m_addr, bus.o_m_wdata} !== '0) begin
         fails++;
         $display("FAIL reset_mem: got req=%0b we=%0b be=%h addr=%h wd=%h want all 0",
                  bus.o_m_req, bus.o_m_we, bus.o_m_be, bus.o_m_addr, bus.o_m_wdata);
      end
      tests++;
      if ({bus.o_if_rvalid, bus.o_d_rvalid, bus.o_d_err, bus.o_if_gnt, bus.o_d_gnt} !== 5'b0) begin
         fails++;
         $display("FAIL reset_resp: got ifv=%0b dv=%0b err=%0b want 0",
                  bus.o_if_rvalid, bus.o_d_rvalid, bus.o_d_err);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_fetch();
      bus.i_if_req  = 1'b1;
      bus.i_if_addr = 32'h0000_0104;
      #1;
      tests++;
      if ({bus.o_if_gnt, bus.o_d_gnt} !== 2'b10) begin
         fails++; $display("FAIL fetch_gnt: got %b want 10", {bus.o_if_gnt, bus.o_d_gnt});
      end
      step();
      bus.i_if_req = 1'b0;
      #1;
      tests++;
      if ({bus.o_m_req, bus.o_m_we, bus.o_m_be, bus.o_m_addr} !== {1'b1, 1'b0, 4'hF, 32'h0000_0104}) begin
         fails++;
         $display("FAIL fetch_mem: got req=%0b we=%0b be=%h addr=%h want 1 0 f 00000104",
                  bus.o_m_req, bus.o_m_we, bus.o_m_be, bus.o_m_addr);
      end
      bus.i_m_ack   = 1'b1;
      bus.i_m_rdata = 32'hDEAD_BEEF;
      step();
      bus.i_m_ack = 1'b0;
      #1;
      tests++;
      if ({bus.o_if_rvalid, bus.o_if_rdata, bus.o_m_req} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
         fails++;
         $display("FAIL fetch_resp: got v=%0b rdata=%h mreq=%0b want 1 deadbeef 0",
                  bus.o_if_rvalid, bus.o_if_rdata, bus.o_m_req);
      end
      step();
   endtask

   task automatic test_store_load();
      // byte store at 0x203
      bus.i_d_req = 1'b1; bus.i_d_we = 1'b1; bus.i_d_size = 2'b01;
      bus.i_d_addr = 32'h0000_0203; bus.i_d_wdata = 32'h0000_00A5;
      #1;
      tests++;
      if (bus.o_d_gnt !== 1'b1) begin
         fails++; $display("FAIL sb_gnt: got %0b want 1", bus.o_d_gnt);
      end
      step();
      bus.i_d_req = 1'b0;
      #1;
      tests++;
      if ({bus.o_m_req, bus.o_m_we, bus.o_m_be, bus.o_m_addr, bus.o_m_wdata} !==
          {1'b1, 1'b1, 4'b1000, 32'h0000_0200, 32'hA5A5_A5A5}) begin
         fails++;
         $display("FAIL sb_mem: got req=%0b we=%0b be=%b addr=%h wd=%h want 1 1 1000 00000200 a5a5a5a5",
                  bus.o_m_req, bus.o_m_we, bus.o_m_be, bus.o_m_addr, bus.o_m_wdata);
      end
      bus.i_m_ack = 1'b1; bus.i_m_rdata = 32'hFFFF_FFFF;
      step();
      bus.i_m_ack = 1'b0;
      #1;
      tests++;
      if ({bus.o_d_rvalid, bus.o_d_err, bus.o_d_rdata} !== {1'b1, 1'b0, 32'd0}) begin
         fails++;
         $display("FAIL sb_resp: got v=%0b err=%0b rdata=%h want 1 0 00000000",
                  bus.o_d_rvalid, bus.o_d_err, bus.o_d_rdata);
      end
      step();

      // half store at 0x202
      bus.i_d_req = 1'b1; bus.i_d_we = 1'b1; bus.i_d_size = 2'b10;
      bus.i_d_addr = 32'h0000_0202; bus.i_d_wdata = 32'h0000_BEEF;
      step();
      bus.i_d_req = 1'b0;
      #1;
      tests++;
      if ({bus.o_m_be, bus.o_m_wdata, bus.o_m_addr} !== {4'b1100, 32'hBEEF_BEEF, 32'h0000_0200}) begin
         fails++;
         $display("FAIL sh_mem: got be=%b wd=%h addr=%h want 1100 beefbeef 00000200",
                  bus.o_m_be, bus.o_m_wdata, bus.o_m_addr);
      end
      bus.i_m_ack = 1'b1;
      step();
      bus.i_m_ack = 1'b0;
      step();

      // half load at 0x202
      bus.i_d_req = 1'b1; bus.i_d_we = 1'b0; bus.i_d_size = 2'b10;
      bus.i_d_addr = 32'h0000_0202; bus.i_d_wdata = '0;
      step();
      bus.i_d_req = 1'b0;
      #1;
      tests++;
      if ({bus.o_m_we, bus.o_m_be, bus.o_m_addr} !== {1'b0, 4'b1111, 32'h0000_0200}) begin
         fails++;
         $display("FAIL lh_mem: got we=%0b be=%b addr=%h want 0 1111 00000200",
                  bus.o_m_we, bus.o_m_be, bus.o_m_addr);
      end
      bus.i_m_ack = 1'b1; bus.i_m_rdata = 32'h1234_5678;
      step();
      bus.i_m_ack = 1'b0;
      #1;
      tests++;
      if ({bus.o_d_rvalid, bus.o_d_rdata} !== {1'b1, 32'h0000_1234}) begin
         fails++;
         $display("FAIL lh_resp: got v=%0b rdata=%h want 1 00001234", bus.o_d_rvalid, bus.o_d_rdata);
      end
      step();

      // byte load at 0x201
      bus.i_d_req = 1'b1; bus.i_d_size = 2'b01; bus.i_d_addr = 32'h0000_0201;
      step();
      bus.i_d_req = 1'b0;
      bus.i_m_ack = 1'b1; bus.i_m_rdata = 32'h1234_5678;
      step();
      bus.i_m_ack = 1'b0;
      #1;
      tests++;
      if ({bus.o_d_rvalid, bus.o_d_rdata} !== {1'b1, 32'h0012_3456}) begin
         fails++;
         $display("FAIL lb_resp: got v=%0b rdata=%h want 1 00123456", bus.o_d_rvalid, bus.o_d_rdata);
      end
      step();
   endtask

   task automatic test_starve();
      logic [9:0] exp_if;
      exp_if = 10'b10_0001_0000;
      bus.i_if_req = 1'b1; bus.i_if_addr = 32'h0000_0800;
      bus.i_d_req = 1'b1; bus.i_d_we = 1'b0; bus.i_d_size = 2'b11; bus.i_d_addr = 32'h0000_0400;
      for (int i = 0; i < 10; i++) begin
         #1;
         tests++;
         if ({bus.o_if_gnt, bus.o_d_gnt} !== (exp_if[i] ? 2'b10 : 2'b01)) begin
            fails++;
            $display("FAIL starve_order[%0d]: got if/d=%b want %b", i,
                     {bus.o_if_gnt, bus.o_d_gnt}, exp_if[i] ? 2'b10 : 2'b01);
         end
         step();
         #1;
         tests++;
         if ({bus.o_if_gnt, bus.o_d_gnt, bus.o_m_req} !== 3'b001) begin
            fails++;
            $display("FAIL starve_busy[%0d]: got if/d/mreq=%b want 001", i,
                     {bus.o_if_gnt, bus.o_d_gnt, bus.o_m_req});
         end
         bus.i_m_ack = 1'b1; bus.i_m_rdata = 32'(i);
         step();
         bus.i_m_ack = 1'b0;
      end
      bus.i_if_req = 1'b0; bus.i_d_req = 1'b0;
      step();
   endtask

   task automatic test_delayed_ack();
      bus.i_d_req = 1'b1; bus.i_d_we = 1'b0; bus.i_d_size = 2'b11; bus.i_d_addr = 32'h0000_0500;
      #1;
      tests++;
      if (bus.o_d_gnt !== 1'b1) begin
         fails++; $display("FAIL dly_gnt: got %0b want 1", bus.o_d_gnt);
      end
      step();
      bus.i_d_req = 1'b0;
      bus.i_if_req = 1'b1; bus.i_if_addr = 32'h0000_0900;
      for (int k = 0; k < 5; k++) begin
         if (k == 4) begin
            bus.i_m_ack = 1'b1; bus.i_m_rdata = 32'h55AA_1234;
         end
         #1;
         tests++;
         if ({bus.o_m_req, bus.o_m_addr, bus.o_m_be, bus.o_if_gnt, bus.o_d_rvalid} !==
             {1'b1, 32'h0000_0500, 4'hF, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL dly_hold[%0d]: got req=%0b addr=%h be=%h ifgnt=%0b dv=%0b want 1 00000500 f 0 0",
                     k, bus.o_m_req, bus.o_m_addr, bus.o_m_be, bus.o_if_gnt, bus.o_d_rvalid);
         end
         step();
      end
      bus.i_m_ack = 1'b0;
      #1;
      tests++;
      if ({bus.o_d_rvalid, bus.o_d_rdata, bus.o_if_gnt} !== {1'b1, 32'h55AA_1234, 1'b1}) begin
         fails++;
         $display("FAIL dly_resp: got v=%0b rdata=%h ifgnt=%0b want 1 55aa1234 1",
                  bus.o_d_rvalid, bus.o_d_rdata, bus.o_if_gnt);
      end
      step();
      bus.i_if_req = 1'b0;
      #1;
      tests++;
      if ({bus.o_d_rvalid, bus.o_m_addr} !== {1'b0, 32'h0000_0900}) begin
         fails++;
         $display("FAIL dly_pulse: got dv=%0b addr=%h want 0 00000900", bus.o_d_rvalid, bus.o_m_addr);
      end
      bus.i_m_ack = 1'b1; bus.i_m_rdata = 32'h0BAD_F00D;
      step();
      bus.i_m_ack = 1'b0;
      #1;
      tests++;
      if ({bus.o_if_rvalid, bus.o_if_rdata} !== {1'b1, 32'h0BAD_F00D}) begin
         fails++;
         $display("FAIL dly_fetch: got v=%0b rdata=%h want 1 0badf00d", bus.o_if_rvalid, bus.o_if_rdata);
      end
      step();
   endtask

   task automatic test_reset_inflight();
      bus.i_d_req = 1'b1; bus.i_d_we = 1'b0; bus.i_d_size = 2'b11; bus.i_d_addr = 32'h0000_0600;
      step();
      bus.i_d_req = 1'b0;
      #1;
      tests++;
      if (bus.o_m_req !== 1'b1) begin
         fails++; $display("FAIL rst_busy: got mreq=%0b want 1", bus.o_m_req);
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      tests++;
      if ({bus.o_m_req, bus.o_m_we, bus.o_m_be, bus.o_m_addr, bus.o_m_wdata,
           bus.o_d_rvalid, bus.o_if_rvalid, bus.o_d_err, bus.o_d_rdata} !== '0) begin
         fails++;
         $display("FAIL rst_outputs: got mreq=%0b be=%h addr=%h dv=%0b ifv=%0b err=%0b want all 0",
                  bus.o_m_req, bus.o_m_be, bus.o_m_addr, bus.o_d_rvalid, bus.o_if_rvalid, bus.o_d_err);
      end
      bus.i_m_ack = 1'b1; bus.i_m_rdata = 32'hFFFF_FFFF;
      step();
      bus.i_m_ack = 1'b0;
      #1;
      tests++;
      if ({bus.o_d_rvalid, bus.o_m_req} !== 2'b00) begin
         fails++;
         $display("FAIL rst_late_ack: got dv=%0b mreq=%0b want 0 0", bus.o_d_rvalid, bus.o_m_req);
      end
      step();
   endtask

   task automatic test_invalid_size();
      bus.i_d_req = 1'b1; bus.i_d_we = 1'b1; bus.i_d_size = 2'b00; bus.i_d_addr = 32'h0000_0700;
      #1;
      tests++;
      if (bus.o_d_gnt !== 1'b1) begin
         fails++; $display("FAIL inv_gnt: got %0b want 1", bus.o_d_gnt);
      end
      step();
      bus.i_d_req = 1'b0;
      bus.i_if_req = 1'b1; bus.i_if_addr = 32'h0000_0A00;
      #1;
      tests++;
      if ({bus.o_d_rvalid, bus.o_d_err, bus.o_m_req, bus.o_if_gnt} !== 4'b1101) begin
         fails++;
         $display("FAIL inv_resp: got dv/err/mreq/ifgnt=%b want 1101",
                  {bus.o_d_rvalid, bus.o_d_err, bus.o_m_req, bus.o_if_gnt});
      end
      step();
      bus.i_if_req = 1'b0;
      #1;
      tests++;
      if ({bus.o_d_rvalid, bus.o_d_err, bus.o_m_req, bus.o_m_addr} !== {3'b001, 32'h0000_0A00}) begin
         fails++;
         $display("FAIL inv_next: got dv=%0b err=%0b mreq=%0b addr=%h want 0 0 1 00000a00",
                  bus.o_d_rvalid, bus.o_d_err, bus.o_m_req, bus.o_m_addr);
      end
      bus.i_m_ack = 1'b1;
      step();
      bus.i_m_ack = 1'b0;
      step();
   endtask

   task automatic test_misalign();
      bus.i_d_req = 1'b1; bus.i_d_we = 1'b0; bus.i_d_size = 2'b11; bus.i_d_addr = 32'h0000_0302;
      step();
      bus.i_d_req = 1'b0;
      #1;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
      tests++;
      if ({bus.o_d_rvalid, bus.o_d_err, bus.o_m_req} !== 3'b110) begin
         fails++;
         $display("FAIL mis_err: got dv/err/mreq=%b want 110", {bus.o_d_rvalid, bus.o_d_err, bus.o_m_req});
      end
      step();
      #1;
      tests++;
      if (bus.o_m_req !== 1'b0) begin
         fails++; $display("FAIL mis_noreq: got mreq=%0b want 0", bus.o_m_req);
      end
`else
      tests++;
      if ({bus.o_m_req, bus.o_m_addr, bus.o_d_err} !== {1'b1, 32'h0000_0300, 1'b0}) begin
         fails++;
         $display("FAIL mis_align: got mreq=%0b addr=%h err=%0b want 1 00000300 0",
                  bus.o_m_req, bus.o_m_addr, bus.o_d_err);
      end
      bus.i_m_ack = 1'b1; bus.i_m_rdata = 32'hCAFE_F00D;
      step();
      bus.i_m_ack = 1'b0;
      #1;
      tests++;
      if ({bus.o_d_rvalid, bus.o_d_err, bus.o_d_rdata} !== {2'b10, 32'hCAFE_F00D}) begin
         fails++;
         $display("FAIL mis_resp: got dv=%0b err=%0b rdata=%h want 1 0 cafef00d",
                  bus.o_d_rvalid, bus.o_d_err, bus.o_d_rdata);
      end
`endif
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_fetch();
      test_store_load();
      test_starve();
      test_delayed_ack();
      test_reset_inflight();
      test_invalid_size();
      test_misalign();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

`default_nettype wire
